// File: rtl/l1_layer_infer.sv
// ODESA L1 inference layer: per-channel decaying time surfaces feed two neurons
// evaluated by a sequential 8-step dot product, with winner-take-all spike and decaying traces.
module l1_layer_infer #(
  parameter int p_width         = 9,
  parameter int p_ts_decay_clks = 4,
  parameter int p_tr_decay_clks = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [8:1]                 i_event,
  input  logic [2*8*p_width-1:0]     i_weights,
  input  logic [2*(2*p_width+3)-1:0] i_thresholds,
  output logic [2:1]                 o_spike,
  output logic [2*8*p_width-1:0]     o_ts,
  output logic [2*p_width-1:0]       o_tr,
  output logic [2*(2*p_width+3)-1:0] o_lv,
  output logic                       o_busy
);
  localparam int pw    = 2 * p_width;
  localparam int lw    = 2 * p_width + 3;
  localparam int ts_cw = (p_ts_decay_clks > 1) ? $clog2(p_ts_decay_clks) : 1;
  localparam int tr_cw = (p_tr_decay_clks > 1) ? $clog2(p_tr_decay_clks) : 1;
  localparam logic [p_width-1:0] val_max = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DECIDE} state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [ts_cw-1:0]   ts_cnt_q, ts_cnt_d;
  logic [tr_cw-1:0]   tr_cnt_q, tr_cnt_d;
  logic [p_width-1:0] ts_q [8];
  logic [p_width-1:0] ts_d [8];
  logic [p_width-1:0] tr_q [2];
  logic [p_width-1:0] tr_d [2];
  logic [p_width-1:0] snap_q [8];
  logic [p_width-1:0] snap_d [8];
  logic [p_width-1:0] w_q [2][8];
  logic [p_width-1:0] w_d [2][8];
  logic [lw-1:0]      thr_q [2];
  logic [lw-1:0]      thr_d [2];
  logic [lw-1:0]      acc_q [2];
  logic [lw-1:0]      acc_d [2];
  logic [lw-1:0]      lv_q [2];
  logic [lw-1:0]      lv_d [2];
  logic [2:0]         idx_q, idx_d;
  logic [2:1]         spike_q, spike_d;
  logic               busy_q, busy_d;

  logic               ev, ts_tick, tr_tick;
  logic [pw-1:0]      prod [2];
  logic [1:0]         fire, win;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred; blocking '=' is correct in comb logic.
  always_comb begin
    ev       = |i_event;
    ts_tick  = (ts_cnt_q == ts_cw'(p_ts_decay_clks - 1));
    tr_tick  = (tr_cnt_q == tr_cw'(p_tr_decay_clks - 1));
    ts_cnt_d = ts_tick ? '0 : ts_cnt_q + ts_cw'(1);
    tr_cnt_d = tr_tick ? '0 : tr_cnt_q + tr_cw'(1);

    for (int k = 0; k < 8; k++) begin
      if (i_event[k+1])                   ts_d[k] = val_max;
      else if (ts_tick && ts_q[k] != '0)  ts_d[k] = ts_q[k] - p_width'(1);
      else                                ts_d[k] = ts_q[k];
    end

    for (int n = 0; n < 2; n++)
      prod[n] = pw'(w_q[n][idx_q]) * pw'(snap_q[idx_q]);

    state_d = state_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    w_d     = w_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    lv_d    = lv_q;
    idx_d   = idx_q;
    fire    = '0;
    win     = '0;

    case (state_q)
      S_IDLE: begin
        if (ev || pend_q) begin
          state_d = S_LOAD;
          pend_d  = 1'b0;
        end
      end
      S_LOAD: begin
        pend_d = pend_q | ev;
        snap_d = ts_q;
        for (int n = 0; n < 2; n++) begin
          for (int k = 0; k < 8; k++)
            w_d[n][k] = i_weights[p_width*(8*n+k) +: p_width];
          thr_d[n] = i_thresholds[lw*n +: lw];
          acc_d[n] = '0;
        end
        idx_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        pend_d = pend_q | ev;
        for (int n = 0; n < 2; n++)
          acc_d[n] = acc_q[n] + lw'(prod[n]);
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        lv_d = acc_q;
        for (int n = 0; n < 2; n++)
          fire[n] = (acc_q[n] >= thr_q[n]);
        // Both firing: larger level wins, a tie goes to neuron 1.
        if (fire == 2'b11) win = (acc_q[1] > acc_q[0]) ? 2'b10 : 2'b01;
        else               win = fire;
        state_d = (pend_q || ev) ? S_LOAD : S_IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    spike_d = {win[1], win[0]};
    for (int n = 0; n < 2; n++) begin
      if (win[n])                         tr_d[n] = val_max;
      else if (tr_tick && tr_q[n] != '0)  tr_d[n] = tr_q[n] - p_width'(1);
      else                                tr_d[n] = tr_q[n];
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      ts_cnt_q <= '0;
      tr_cnt_q <= '0;
      ts_q     <= '{default: '0};
      tr_q     <= '{default: '0};
      acc_q    <= '{default: '0};
      lv_q     <= '{default: '0};
      idx_q    <= '0;
      spike_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ts_cnt_q <= ts_cnt_d;
      tr_cnt_q <= tr_cnt_d;
      ts_q     <= ts_d;
      tr_q     <= tr_d;
      acc_q    <= acc_d;
      lv_q     <= lv_d;
      idx_q    <= idx_d;
      spike_q  <= spike_d;
      busy_q   <= busy_d;
    end
  end

  // NOTE: snapshot registers are always written in LOAD before MAC reads them,
  // so they carry no reset and need no reset fan-out.
  always_ff @(posedge i_clk) begin
    snap_q <= snap_d;
    w_q    <= w_d;
    thr_q  <= thr_d;
  end

  always_comb begin
    o_ts = '0;
    o_tr = '0;
    o_lv = '0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++)
        o_ts[p_width*(8*n+k) +: p_width] = ts_q[k];
      o_tr[p_width*n +: p_width] = tr_q[n];
      o_lv[lw*n +: lw]           = lv_q[n];
    end
  end

  assign o_spike = spike_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_l1_layer_infer.sv
// Directed bench for l1_layer_infer: table of single-evaluation vectors plus
// hand-written sequences for reset, back-to-back evaluation, decay and mid-evaluation reset.
module tb_l1_layer_infer;
  localparam int W  = 9;
  localparam int LW = 2 * W + 3;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [8:1]          i_event = '0;
  logic [2*8*W-1:0]    i_weights = '0;
  logic [2*LW-1:0]     i_thresholds = '0;
  logic [2:1]          o_spike;
  logic [2*8*W-1:0]    o_ts;
  logic [2*W-1:0]      o_tr;
  logic [2*LW-1:0]     o_lv;
  logic                o_busy;

  l1_layer_infer #(.p_width(W), .p_ts_decay_clks(4), .p_tr_decay_clks(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_event(i_event), .i_weights(i_weights),
    .i_thresholds(i_thresholds), .o_spike(o_spike), .o_ts(o_ts), .o_tr(o_tr),
    .o_lv(o_lv), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [8:1]    ev;
    logic [W-1:0]  w_all;
    logic [W-1:0]  w2_1;
    logic [LW-1:0] thr;
    logic [LW-1:0] lv1;
    logic [LW-1:0] lv2;
    logic [2:1]    spk;
  } vec_t;

  vec_t vecs [7];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         busy_cnt, spk_cnt, both_cnt, lat, quiet_spk, quiet_busy;
  logic [2:1] spk_seen;
  logic [W-1:0] tr1_at, tr2_at;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_event = '0;
    repeat (3) tick();
    i_rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [W-1:0] w_all, input logic [W-1:0] w2_1,
                         input logic [LW-1:0] thr);
    for (int i = 0; i < 16; i++) i_weights[W*i +: W] = w_all;
    i_weights[W*8 +: W] = w2_1;
    i_thresholds = {thr, thr};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ev: 8'h01, w_all: 63,  w2_1: 63,  thr: 32767, lv1: 32193,   lv2: 32193,   spk: 2'b00};
    vecs[1] = '{ev: 8'h03, w_all: 63,  w2_1: 63,  thr: 32767, lv1: 64386,   lv2: 64386,   spk: 2'b01};
    vecs[2] = '{ev: 8'h01, w_all: 63,  w2_1: 127, thr: 32767, lv1: 32193,   lv2: 64897,   spk: 2'b10};
    vecs[3] = '{ev: 8'h03, w_all: 63,  w2_1: 127, thr: 32767, lv1: 64386,   lv2: 97090,   spk: 2'b10};
    vecs[4] = '{ev: 8'hFF, w_all: 511, w2_1: 511, thr: 32767, lv1: 2088968, lv2: 2088968, spk: 2'b01};
    vecs[5] = '{ev: 8'h01, w_all: 63,  w2_1: 63,  thr: 32193, lv1: 32193,   lv2: 32193,   spk: 2'b01};
    vecs[6] = '{ev: 8'h01, w_all: 63,  w2_1: 63,  thr: 32194, lv1: 32193,   lv2: 32193,   spk: 2'b00};

    // Reset state, held for 3 cycles, then quiet after release.
    repeat (3) tick();
    check("rst_spike", o_spike, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_ts",    o_ts, 0);
    check("rst_tr",    o_tr, 0);
    check("rst_lv",    o_lv, 0);
    i_rst = 1'b0;
    repeat (5) tick();
    check("idle_spike", o_spike, 0);
    check("idle_busy",  o_busy, 0);
    check("idle_ts",    o_ts, 0);
    check("idle_lv",    o_lv, 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_cfg(vecs[v].w_all, vecs[v].w2_1, vecs[v].thr);
      i_event = vecs[v].ev;
      tick();
      i_event  = '0;
      busy_cnt = 0; spk_cnt = 0; both_cnt = 0; lat = 0;
      spk_seen = '0; tr1_at = '0; tr2_at = '0;
      for (int c = 0; c < 30; c++) begin
        if (o_busy) busy_cnt++;
        tick();
        if (o_spike != 2'b00) begin
          spk_cnt++;
          if (o_spike == 2'b11) both_cnt++;
          if (lat == 0) begin
            lat = c + 1; spk_seen = o_spike; tr1_at = o_tr[W-1:0]; tr2_at = o_tr[2*W-1:W];
          end
        end
      end
      check($sformatf("v%0d_lv1", v), o_lv[LW-1:0], vecs[v].lv1);
      check($sformatf("v%0d_lv2", v), o_lv[2*LW-1:LW], vecs[v].lv2);
      check($sformatf("v%0d_busy_cycles", v), busy_cnt, 10);
      check($sformatf("v%0d_spike", v), spk_seen, vecs[v].spk);
      check($sformatf("v%0d_spike_cycles", v), spk_cnt, (vecs[v].spk != 2'b00) ? 1 : 0);
      check($sformatf("v%0d_both_bits", v), both_cnt, 0);
      if (vecs[v].spk != 2'b00) begin
        check($sformatf("v%0d_latency", v), lat, 10);
        check($sformatf("v%0d_tr1_at_spike", v), tr1_at, vecs[v].spk[1] ? 511 : 0);
        check($sformatf("v%0d_tr2_at_spike", v), tr2_at, vecs[v].spk[2] ? 511 : 0);
        // 20 edges after the spike load = 5 trace ticks.
        check($sformatf("v%0d_tr1_decay", v), o_tr[W-1:0], vecs[v].spk[1] ? 506 : 0);
        check($sformatf("v%0d_tr2_decay", v), o_tr[2*W-1:W], vecs[v].spk[2] ? 506 : 0);
      end
    end

    // Back-to-back: second event during MAC keeps o_busy high for 20 cycles.
    do_reset();
    set_cfg(63, 63, 32767);
    i_event = 8'h01;
    tick();
    i_event  = '0;
    busy_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (!o_busy) break;
      busy_cnt++;
      i_event = (c == 3) ? 8'h02 : 8'h00;
      tick();
      if (c == 3) check("b2b_ts2_load", o_ts[2*W-1:W], 511);
    end
    i_event = '0;
    check("b2b_busy_cycles", busy_cnt, 20);

    // Time-surface decay: 40 edges = 10 ticks, then saturation at 0.
    do_reset();
    i_event = 8'h01;
    tick();
    i_event = '0;
    check("decay_ts1_load", o_ts[W-1:0], 511);
    repeat (40) tick();
    check("decay_ts1_n1", o_ts[W-1:0], 501);
    check("decay_ts1_n2", o_ts[8*W +: W], 501);
    check("decay_ts2", o_ts[2*W-1:W], 0);
    repeat (2100) tick();
    check("decay_ts1_sat", o_ts[W-1:0], 0);

    // Reset at E5 of a firing evaluation aborts it with no spike.
    set_cfg(63, 63, 32767);
    i_event = 8'h03;
    tick();
    i_event = '0;
    repeat (4) tick();
    i_rst = 1'b1;
    tick();
    check("abort_spike", o_spike, 0);
    check("abort_busy",  o_busy, 0);
    check("abort_ts",    o_ts, 0);
    check("abort_tr",    o_tr, 0);
    check("abort_lv",    o_lv, 0);
    i_rst = 1'b0;
    quiet_spk = 0; quiet_busy = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_spike != 2'b00) quiet_spk++;
      if (o_busy) quiet_busy++;
    end
    check("abort_no_spike_after", quiet_spk, 0);
    check("abort_no_busy_after",  quiet_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l1_layer_infer.md
# l1_layer_infer

Inference side of the ODESA L1 layer: two neurons over eight input event channels, fed with trained weights and thresholds from the L1 trainer. It keeps a decaying time surface per input channel and, on every input event, computes each neuron's level as a sequential dot product. It fires the winning neuron and maintains decaying output traces. Its outputs drive the trainer's spike, time-surface, trace and level inputs and the next layer's event inputs.

## Interface
- p_width, 9, bit width of time surfaces, traces and weights
- p_ts_decay_clks, 4, clocks per time-surface decrement tick (≥1)
- p_tr_decay_clks, 4, clocks per trace decrement tick (≥1)
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous and active-high
- i_event  in  [8:1]  input event channels; any bit high in a cycle is one event on that channel
- i_weights  in  2*8*p_width  packed {w8[2]..w1[2], w8[1]..w1[1]}; neuron n weight k at bit offset p_width*(8*(n-1)+k-1)
- i_thresholds  in  2*(2*p_width+3)  packed {thr[2], thr[1]}
- o_spike  out  [2:1]  one-cycle winner spike
- o_ts  out  2*8*p_width  live time surface, same packing as i_weights, identical for both neurons
- o_tr  out  2*p_width  traces {tr[2], tr[1]}
- o_lv  out  2*(2*p_width+3)  levels {lv[2], lv[1]} from the last evaluation
- o_busy  out  1  high while the FSM is not in IDLE

## Operation
- Time surface ts[k], one per channel:
  - i_event[k] set at an edge loads ts[k] to 2^p_width-1.
  - Otherwise, on each decay tick, a nonzero ts[k] decrements by 1 and saturates at 0.
  - If an event and a tick coincide on the same channel, the event wins.
- Decay tick: a free-running prescaler that pulses once every p_ts_decay_clks clocks. Traces use their own prescaler with period p_tr_decay_clks.
- Event handling runs in every state. Time surfaces update immediately. Any event while the FSM is not in IDLE sets a 1-bit pending flag; multiple events merge into that one flag.
- FSM states: IDLE, LOAD, MAC, DECIDE.
  - IDLE: if an event or pending is present → LOAD, and pending clears.
  - LOAD: snapshot ts[1..8], all weights and both thresholds; clear both accumulators; idx=1; → MAC.
  - MAC: acc[n] += w[n][idx]*snap[idx] for both neurons in parallel; idx increments; after idx=8 → DECIDE.
  - DECIDE:
    - lv[n] ← acc[n] and fire[n] = lv[n] ≥ thr[n].
    - If both fire, the larger lv wins; a tie goes to neuron 1. If neither fires, there is no spike.
    - The winner's o_spike bit goes high next cycle, and the winner's tr loads 2^p_width-1.
    - → LOAD if pending is set or an event arrives at this edge (pending clears), else → IDLE.
- Arithmetic:
  - Unsigned throughout. Each product is 2*p_width bits; each accumulator is 2*p_width+3 bits.
  - The maximum value 8*511*511 fits, so there is no saturation and no wrap.
- Trace tr[n] decrements by 1 per trace tick and saturates at 0. A spike coinciding with a tick loads the maximum.
- Weight and threshold changes after LOAD do not affect the evaluation in flight.

## Timing
- Reset:
  - All ts, tr, lv, accumulators, prescalers and pending clear to 0.
  - o_spike=0, o_busy=0, FSM=IDLE.
  - Reset mid-evaluation aborts it with no spike.
- Edge E0 samples an event in IDLE: ts loads at E0, and the FSM goes to LOAD.
  - E1: LOAD.
  - E2–E9: the eight MAC steps.
  - E10: DECIDE. o_lv updates and the o_spike bit is high for exactly the cycle after E10.
- Event-to-spike latency is 10 clocks. o_busy is high for the 10 cycles after E0.
- With pending set, back-to-back evaluations run with no IDLE cycle and o_busy stays high.
- o_spike is never high for both bits at once, and never for more than one cycle per evaluation.

## Test plan
- Reset → o_spike=0, o_busy=0, o_ts=0, o_tr=0, o_lv=0; reset held 3 cycles then released → outputs stay 0 with no events.
- All weights 63, thresholds 32767, i_event=8'h01 one cycle → after 10 clocks lv1=lv2=32193, no spike, o_busy high exactly 10 cycles.
- Same setup, i_event=8'h03 → lv1=lv2=64386, tie, o_spike=2'b01 for one cycle 10 clocks after the event, tr[1]=511, tr[2]=0.
- Neuron 2 weight 1 set to 127, i_event=8'h01 → lv1=32193, lv2=64897, o_spike=2'b10.
- Event on ch1, then a second event on ch2 during MAC → second evaluation starts immediately after DECIDE, o_busy high 20 cycles. Idle with p_ts_decay_clks=4 → ts[1]=501 after 40 cycles, and 0 at saturation.
- i_rst asserted at E5 of an evaluation with a firing configuration → no spike, all outputs 0 the cycle after reset.
